// File: rtl/display7_scan.sv
// display7_scan: multiplexed common-anode 7-segment driver.
//   Scans DIGITS digits from a load-strobed shadow copy of a packed nibble bus, with a
//   scan prescaler, hex/decimal decode, optional leading-zero blanking, per-digit decimal
//   points and a global enable. All outputs are registered (one cycle behind idx/shadow/iEn).
// Ports:
//   iClk    - system clock
//   iRst_n  - asynchronous active-low reset
//   iData   - packed nibbles, digit i = iData[4i+3:4i], digit 0 rightmost
//   iDp     - decimal-point request per digit, 1 = lit
//   iLoad   - captures iData/iDp into the shadow registers
//   iEn     - 1 = display on, 0 = all anodes off
//   oSeg    - segments a..g on bits 0..6, active-low
//   oDp     - decimal point, active-low
//   oAn     - anodes, active-low, one-hot-low when enabled
module display7_scan #(
   parameter int unsigned DIGITS   = 8,
   parameter int unsigned SCAN_DIV = 100000,
   parameter int unsigned HEX_MODE = 1,
   parameter int unsigned LZ_BLANK = 0
) (
   input  logic                  iClk,
   input  logic                  iRst_n,
   input  logic [4*DIGITS-1:0]   iData,
   input  logic [DIGITS-1:0]     iDp,
   input  logic                  iLoad,
   input  logic                  iEn,
   output logic [6:0]            oSeg,
   output logic                  oDp,
   output logic [DIGITS-1:0]     oAn
);

   localparam int unsigned CntW = $clog2(SCAN_DIV);
   localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [4*DIGITS-1:0] shadow_q, shadow_d;
   logic [DIGITS-1:0]   dp_q, dp_d;
   logic [6:0]          seg_q, seg_d;
   logic                dpo_q, dpo_d;
   logic [DIGITS-1:0]   an_q, an_d;

   logic [DIGITS-1:0]   blank;
   logic                zero_run;
   logic [3:0]          nib_sel;
   logic                dp_sel;
   logic                blank_sel;

   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] s;
      unique case (nib)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      if (HEX_MODE == 0 && nib > 4'h9) s = 7'b1111111;
      return s;
   endfunction

   // Walk from the most significant digit down; a digit is blanked while every nibble from
   // the top down to it is zero. Digit 0 is never blanked.
   always_comb begin
      zero_run = 1'b1;
      blank    = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (shadow_q[4*i +: 4] == 4'h0);
         blank[i] = (LZ_BLANK != 0) && (i != 0) && zero_run;
      end
   end

   always_comb begin
      nib_sel   = 4'h0;
      dp_sel    = 1'b0;
      blank_sel = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IdxW'(i)) begin
            nib_sel   = shadow_q[4*i +: 4];
            dp_sel    = dp_q[i];
            blank_sel = blank[i];
         end
      end
   end

   always_comb begin
      shadow_d = iLoad ? iData : shadow_q;
      dp_d     = iLoad ? iDp : dp_q;

      cnt_d = cnt_q + CntW'(1);
      idx_d = idx_q;
      if (cnt_q == CntW'(SCAN_DIV - 1)) begin
         cnt_d = '0;
         idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
      end

      for (int i = 0; i < DIGITS; i++) begin
         an_d[i] = !(iEn && (idx_q == IdxW'(i)));
      end

      if (!iEn || blank_sel) begin
         seg_d = 7'b1111111;
         dpo_d = 1'b1;
      end else begin
         seg_d = decode(nib_sel);
         dpo_d = ~dp_sel;
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         dp_q     <= '0;
         seg_q    <= 7'b1111111;
         dpo_q    <= 1'b1;
         an_q     <= '1;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         dp_q     <= dp_d;
         seg_q    <= seg_d;
         dpo_q    <= dpo_d;
         an_q     <= an_d;
      end
   end

   assign oSeg = seg_q;
   assign oDp  = dpo_q;
   assign oAn  = an_q;

endmodule

// File: doc/display7_scan.md
Name: display7_scan

Overview:
- Parametrised successor to the single-digit combinational 7-segment decoder.
- Drives a DIGITS-wide multiplexed common-anode display from a packed nibble bus; only one anode is active at a time.
- Adds a scan prescaler, a load-strobed shadow register, hex/decimal mode, leading-zero blanking, per-digit decimal points and a global enable.
- Sits between the datapath (counters, BCD converters) and the board's segment/anode pins.

Parameters:
- DIGITS, 8: number of digits scanned; legal range 1..16.
- SCAN_DIV, 100000: clock cycles per digit slot; must be ≥2.
- HEX_MODE, 1: 1 = codes 10-15 show A,b,C,d,E,F; 0 = codes 10-15 shown blank.
- LZ_BLANK, 0: 1 = suppress leading zeros; digit 0 is never blanked.

Ports:
- iClk  input  1  system clock.
- iRst_n  input  1  asynchronous active-low reset.
- iData  input  4*DIGITS  packed nibbles; digit i = iData[4i+3:4i]; digit 0 is rightmost.
- iDp  input  DIGITS  decimal-point request per digit, 1 = lit.
- iLoad  input  1  strobe; captures iData/iDp into the shadow registers.
- iEn  input  1  1 = display on; 0 = all anodes off.
- oSeg  output  7  segments, active-low; oSeg[0]=a … oSeg[6]=g.
- oDp  output  1  decimal point, active-low.
- oAn  output  DIGITS  anodes, active-low, one-hot-low when on.

Behaviour:
- Clocking and reset:
  - One clock, iClk; reset is asynchronous and active-low on iRst_n.
  - Reset clears prescaler, scan index idx, shadow data and shadow dp to 0.
  - Reset drives oAn all 1, oSeg = 7'b1111111, oDp = 1.
  - Asserting reset mid-scan returns everything to these values immediately, without waiting for an edge.
- Shadow registers:
  - On a rising edge with iLoad = 1, shadow ← iData and dp ← iDp.
  - Otherwise the shadow holds. Display content changes only via iLoad.
- Prescaler and scan:
  - cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - On the edge where cnt == SCAN_DIV-1, idx advances. It wraps from DIGITS-1 to 0.
  - Scanning runs regardless of iEn.
  - With DIGITS = 1, idx stays 0.
- Outputs:
  - All outputs are registered, with 1-cycle latency from idx, shadow and iEn.
  - oAn[idx] = 0 and all other anode bits = 1 when iEn = 1; oAn = all 1 when iEn = 0.
  - oSeg = decode(shadow nibble idx) and oDp = ~dp[idx] when the digit is shown.
  - When iEn = 0 or the digit is blanked, oSeg = 7'b1111111 and oDp = 1.
- Decode table, oSeg[6:0]:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
  - With HEX_MODE = 0, codes 10-15 decode to 1111111.
- Leading-zero blanking (LZ_BLANK = 1):
  - Digit i > 0 is blanked when nibbles DIGITS-1 down to i are all 0.
  - A blanked digit's dp is suppressed too, even if requested.
  - Digit 0 always shows.
  - Blanking uses the shadow value, not live iData.
- Simultaneous events:
  - iLoad on the same edge as an idx advance: the new idx uses the new shadow one cycle later.
  - No glitch: exactly one anode low per cycle while iEn = 1.

Test Plan:
- Reset check (DIGITS=4, SCAN_DIV=4): hold iRst_n = 0, toggle clock → oAn = 4'b1111, oSeg = 7'b1111111, oDp = 1. Release reset with iEn = 1, no load → oAn sequence 1110, 1101, 1011, 0111, 1110, each for 4 cycles; oSeg = 1000000 ('0') on every digit.
- Load data: load iData = 16'h1234, iDp = 4'b0100 → digit0 oSeg 0011001, digit1 0110000, digit2 0100100 with oDp = 0, digit3 1111001. Change iData without iLoad → output unchanged.
- Mode check: load 16'h00AF with HEX_MODE = 1 → digit0 0001110, digit1 0001000. Same load with HEX_MODE = 0 → both digits 1111111.
- Leading-zero blanking: LZ_BLANK = 1, load 16'h0050 → digits 3 and 2 show 1111111; digit1 0010010; digit0 1000000. Load 16'h0000 → only digit0 shows '0'.
- Enable and reset: iEn = 0 mid-scan → oAn = 1111 one cycle later, while idx keeps advancing. iEn = 1 → the anode matching the current idx goes low. Async reset asserted between edges → outputs return to reset values without waiting for a clock edge.
